// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths, reset PC
// and the fetch controller state encoding.
package instr_fetch_unit_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned IMEM_AW_DEF = 10;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned COUNT_W     = 32;

    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural PC register with its next-PC selection (redirect > increment > hold).
module fetch_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next_c
);

    always_comb begin
        pc_next_c = pc;
        if (load) begin
            pc_next_c = load_pc;
        end else if (inc) begin
            pc_next_c = pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next_c;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time and
// presents {pc, instr} to the decoder, discarding responses made stale by redirects.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        IMEM_AW  = IMEM_AW_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               stall,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [COUNT_W-1:0] instr_count
);

    state_t              state;
    state_t              state_next;
    logic                pc_inc;
    logic [ADDR_W-1:0]   pc_next_c;
    logic                req_d;
    logic [IMEM_AW-1:0]  addr_d;
    logic                valid_d;
    logic [INSTR_W-1:0]  instr_d;
    logic [COUNT_W-1:0]  count_d;

    // Redirects are accepted in every state; the FSM only decides whether a fetch is stale.
    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (redirect_valid),
        .load_pc   (redirect_pc),
        .inc       (pc_inc),
        .pc        (pc),
        .pc_next_c (pc_next_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (en) state_next = S_FETCH;
            end
            S_FETCH: begin
                state_next = (redirect_valid || !en) ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (imem_ack) begin
                    if (!en)                 state_next = S_IDLE;
                    else if (redirect_valid) state_next = S_FETCH;
                    else                     state_next = S_HOLD;
                end else if (redirect_valid || !en) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_ack) state_next = en ? S_FETCH : S_IDLE;
            end
            S_HOLD: begin
                if (redirect_valid) state_next = en ? S_FETCH : S_IDLE;
                else if (!en)       state_next = S_IDLE;
                else if (!stall)    state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output next-values; the request pulse and its address track entry into FETCH.
    always_comb begin
        pc_inc  = (state == S_HOLD) && en && !redirect_valid && !stall;
        req_d   = (state_next == S_FETCH);
        addr_d  = req_d ? pc_next_c[IMEM_AW-1:0] : imem_addr;
        valid_d = (state_next == S_HOLD);
        instr_d = (state == S_WAIT && state_next == S_HOLD) ? imem_rdata : instr;
        count_d = pc_inc ? instr_count + COUNT_W'(1) : instr_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_count <= '0;
        end else begin
            imem_req    <= req_d;
            imem_addr   <= addr_d;
            instr_valid <= valid_d;
            instr       <= instr_d;
            instr_count <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory responder, transaction-level
// reference model compared every cycle, plus hand-computed literal checks.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] instr_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc),
        .instr_count    (instr_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: ack arrives ack_delay cycles after the request cycle.
    int          ack_delay = 1;
    int          mem_cd    = 0;
    logic [9:0]  mem_addr  = '0;
    always @(posedge clk) begin
        #1;
        imem_ack = 1'b0;
        if (imem_req) begin
            mem_cd   = ack_delay;
            mem_addr = imem_addr;
        end else if (mem_cd > 0) begin
            mem_cd = mem_cd - 1;
            if (mem_cd == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'h2000_0000 | {22'd0, mem_addr};
            end
        end
    end

    // Reference model: tracks "request issuing", "request in flight (maybe stale)"
    // and "instruction presented" rather than a controller state.
    logic        m_issue = 1'b0;
    logic        m_pend  = 1'b0;
    logic        m_stale = 1'b0;
    logic        m_hold  = 1'b0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_count = '0;
    logic [31:0] m_instr = '0;
    logic [9:0]  m_addr  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_issue <= 1'b0; m_pend <= 1'b0; m_stale <= 1'b0; m_hold <= 1'b0;
            m_pc <= '0; m_count <= '0; m_instr <= '0; m_addr <= '0;
        end else begin
            automatic logic        issue = m_issue;
            automatic logic        pend  = m_pend;
            automatic logic        stale = m_stale;
            automatic logic        hold  = m_hold;
            automatic logic [31:0] npc   = redirect_valid ? redirect_pc : m_pc;
            automatic logic [31:0] cnt   = m_count;
            automatic logic [31:0] ins   = m_instr;
            automatic logic [9:0]  adr   = m_addr;
            if (issue) begin
                issue = 1'b0; pend = 1'b1; stale = redirect_valid || !en;
            end else if (pend) begin
                if (imem_ack) begin
                    pend = 1'b0;
                    if (!stale && !redirect_valid && en) begin
                        hold = 1'b1; ins = imem_rdata;
                    end else begin
                        issue = en;
                    end
                end else begin
                    stale = stale || redirect_valid || !en;
                end
            end else if (hold) begin
                if (redirect_valid) begin
                    hold = 1'b0; issue = en;
                end else if (!en) begin
                    hold = 1'b0;
                end else if (!stall) begin
                    npc = m_pc + 32'd1; cnt = m_count + 32'd1; hold = 1'b0; issue = 1'b1;
                end
            end else begin
                issue = en;
            end
            if (issue) adr = npc[9:0];
            m_issue <= issue; m_pend <= pend; m_stale <= stale; m_hold <= hold;
            m_pc <= npc; m_count <= cnt; m_instr <= ins; m_addr <= adr;
        end
    end

    // Per-cycle comparison plus request/handoff logs for the literal checks.
    logic [9:0]  req_q[$];
    int          rise_cyc[$];
    logic [31:0] rise_pc[$];
    logic [31:0] rise_instr[$];
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        check("model_imem_req", imem_req, m_issue);
        if (m_issue) check("model_imem_addr", imem_addr, m_addr);
        check("model_instr_valid", instr_valid, m_hold);
        check("model_pc", pc, m_pc);
        check("model_instr_count", instr_count, m_count);
        if (m_hold) check("model_instr", instr, m_instr);
        if (imem_req) req_q.push_back(imem_addr);
        if (instr_valid && !prev_valid) begin
            rise_cyc.push_back(cyc);
            rise_pc.push_back(pc);
            rise_instr.push_back(instr);
        end
        prev_valid = instr_valid;
    end

    task automatic wait_valid(input int budget);
        int n = 0;
        @(negedge clk);
        while (!instr_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid_timeout", instr_valid, 1);
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        @(negedge clk);
        while (!imem_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_req_timeout", imem_req, 1);
    endtask

    task automatic wait_count(input logic [31:0] target, input int budget);
        int n = 0;
        while (instr_count != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_count_timeout", instr_count, target);
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] last_req;
        int         stale_seen;
        rst_n = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_pc", pc, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_count", instr_count, 0);
        check("rst_instr", instr, 0);
        check("rst_addr", imem_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_req", imem_req, 0);

        // Sequential fetch of 0,1,2 at one instruction per three cycles.
        en = 1'b1;
        wait_count(32'd3, 30);
        check("req0_addr", req_q[0], 10'h000);
        check("req1_addr", req_q[1], 10'h001);
        check("req2_addr", req_q[2], 10'h002);
        check("hand0_pc", rise_pc[0], 0);
        check("hand1_pc", rise_pc[1], 1);
        check("hand2_pc", rise_pc[2], 2);
        check("hand0_instr", rise_instr[0], 32'h2000_0000);
        check("hand1_instr", rise_instr[1], 32'h2000_0001);
        check("hand2_instr", rise_instr[2], 32'h2000_0002);
        check("spacing01", rise_cyc[1] - rise_cyc[0], 3);
        check("spacing12", rise_cyc[2] - rise_cyc[1], 3);

        // Redirect from HOLD at pc 3 while stalled.
        stall = 1'b1;
        wait_valid(10);
        check("hold3_pc", pc, 3);
        check("hold3_instr", instr, 32'h2000_0003);
        pulse_redirect(32'h14);
        check("redir_valid_drop", instr_valid, 0);
        check("redir_count", instr_count, 3);
        check("redir_req", imem_req, 1);
        check("redir_addr", imem_addr, 10'h014);
        wait_valid(10);
        check("hold14_pc", pc, 32'h14);
        check("hold14_instr", instr, 32'h2000_0014);

        // Stall at pc 4 for five cycles, then resume at pc 5.
        pulse_redirect(32'h4);
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", instr_valid, 1);
            check("stall_pc", pc, 4);
            check("stall_instr", instr, 32'h2000_0004);
            check("stall_no_req", imem_req, 0);
            check("stall_count", instr_count, 3);
        end
        stall = 1'b0;
        wait_valid(10);
        check("resume_pc", pc, 5);
        check("resume_count", instr_count, 4);
        check("resume_instr", instr, 32'h2000_0005);

        // Redirect to 0x40 while the pc 6 fetch is outstanding with a slow memory.
        ack_delay = 3;
        wait_req(10);
        check("slow_req_addr", imem_addr, 10'h006);
        @(negedge clk);
        pulse_redirect(32'h40);
        ack_delay = 1;
        check("drain_no_valid", instr_valid, 0);
        wait_valid(20);
        check("after_drain_pc", pc, 32'h40);
        check("after_drain_instr", instr, 32'h2000_0040);
        last_req = req_q[$];
        check("after_drain_req", last_req, 10'h040);
        stale_seen = 0;
        foreach (rise_instr[i]) if (rise_instr[i] == 32'h2000_0006) stale_seen++;
        check("no_stale_instr", stale_seen, 0);

        // Ack and redirect to 7 in the same WAIT cycle.
        wait_req(10);
        check("simul_req_addr", imem_addr, 10'h041);
        @(negedge clk);
        pulse_redirect(32'h7);
        check("simul_refetch_req", imem_req, 1);
        check("simul_refetch_addr", imem_addr, 10'h007);
        check("simul_no_valid", instr_valid, 0);
        wait_valid(10);
        check("simul_pc", pc, 7);
        check("simul_instr", instr, 32'h2000_0007);
        check("simul_count", instr_count, 6);

        // PC wrap from 0xFFFFFFFF, then asynchronous reset mid-WAIT.
        stall = 1'b1;
        pulse_redirect(32'hFFFF_FFFF);
        wait_valid(10);
        check("wrap_hold_pc", pc, 32'hFFFF_FFFF);
        check("wrap_hold_instr", instr, 32'h2000_03FF);
        check("wrap_hold_count", instr_count, 6);
        ack_delay = 3;
        stall = 1'b0;
        @(negedge clk);
        check("wrap_pc", pc, 0);
        check("wrap_addr", imem_addr, 10'h000);
        check("wrap_count", instr_count, 7);
        check("wrap_req", imem_req, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        check("async_req", imem_req, 0);
        check("async_addr", imem_addr, 0);
        check("async_valid", instr_valid, 0);
        check("async_instr", instr, 0);
        check("async_pc", pc, 0);
        check("async_count", instr_count, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        ack_delay = 1;
        repeat (4) @(negedge clk);
        check("post_rst_idle_valid", instr_valid, 0);
        check("post_rst_idle_req", imem_req, 0);
        en = 1'b1;
        wait_valid(10);
        check("post_rst_pc", pc, 0);
        check("post_rst_instr", instr, 32'h2000_0000);
        check("post_rst_count", instr_count, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
